// File: rtl/blink_pkg.sv
// Shared types and constants for the multi-channel LED blinker.
// Latency: none; this package holds only types and constants.
// Backpressure: none; there is no logic in this package.
package blink_pkg;

  // Width of the channel index field in a configuration write
  localparam int CHAN_IDX_W = 5;

  // Per-channel operating mode
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

endpackage

// File: rtl/blink_chan.sv
// One LED channel: mode/period(/duty) registers, tick counter and registered LED drive.
// Latency: an accepted write forces led low on its own edge; ON lights one edge later; BLINK/PWM advance on ticks.
// Backpressure: none; a write strobe is always absorbed in the cycle it is presented. Duty storage exists only with BLINK_PWM_EN.
module blink_chan
  import blink_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 sync,
  input  logic                 wr_en,
  input  mode_t                wr_mode,
  input  logic [CNT_WIDTH-1:0] wr_period,
`ifdef BLINK_PWM_EN
  input  logic [CNT_WIDTH-1:0] wr_duty,
`endif
  output logic                 led
);

  mode_t                mode_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 cnt_last;
  logic                 led_nxt;
`ifdef BLINK_PWM_EN
  logic [CNT_WIDTH-1:0] duty_q;
  logic [CNT_WIDTH-1:0] phase_nxt;
`endif

  // Mode and period registers, loaded only by a write aimed at this channel.
  // The top hands over a period already forced to at least 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_OFF;
      period_q <= CNT_WIDTH'(1);
    end else if (wr_en) begin
      mode_q   <= wr_mode;
      period_q <= wr_period;
    end
  end

`ifdef BLINK_PWM_EN
  // Duty register for PWM mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_q <= '0;
    end else if (wr_en) begin
      duty_q <= wr_duty;
    end
  end
`endif

  // Next counter and LED value: a write beats sync, and sync beats tick
  always_comb begin
    cnt_nxt  = cnt_q;
    led_nxt  = led;
    cnt_last = (cnt_q == (period_q - CNT_WIDTH'(1)));
`ifdef BLINK_PWM_EN
    phase_nxt = cnt_q;
`endif
    if (wr_en) begin
      cnt_nxt = '0;
      led_nxt = 1'b0;
    end else begin
      case (mode_q)
        MODE_ON: begin
          cnt_nxt = '0;
          led_nxt = 1'b1;
        end
        MODE_BLINK: begin
          if (sync) begin
            cnt_nxt = '0;
            led_nxt = 1'b0;
          end else if (tick) begin
            if (cnt_last) begin
              cnt_nxt = '0;
              led_nxt = ~led;
            end else begin
              cnt_nxt = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
`ifdef BLINK_PWM_EN
        MODE_PWM: begin
          if (sync) begin
            phase_nxt = '0;
          end else if (tick) begin
            phase_nxt = cnt_last ? '0 : (cnt_q + CNT_WIDTH'(1));
          end
          cnt_nxt = phase_nxt;
          // LED follows the phase it is about to hold, so it never lags the counter
          led_nxt = (phase_nxt < duty_q);
        end
`endif
        default: begin
          cnt_nxt = '0;
          led_nxt = 1'b0;
        end
      endcase
    end
  end

  // Counter and LED registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      led   <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      led   <= led_nxt;
    end
  end

endmodule

// File: rtl/blink_multi.sv
// Multi-channel LED blinker: shared tick prescaler, config handshake/decode, CHANNELS x blink_chan.
// Latency: a write lands on its accept edge (led forced low); cfg_err is a one-cycle pulse on the next cycle.
// Backpressure: cfg_ready drops for exactly one cycle after every accepted write. PWM needs BLINK_PWM_EN.
module blink_multi
  import blink_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8,
  parameter int PRESCALE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_IDX_W-1:0] cfg_chan,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [CNT_WIDTH-1:0]  cfg_duty,
  output logic                  cfg_err,
  output logic [CHANNELS-1:0]   led
);

  localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam int                LIM_W    = CHAN_IDX_W + 1;
  localparam logic [LIM_W-1:0]  CHAN_LIM = LIM_W'(CHANNELS);

  logic [PRE_W-1:0]     pre_cnt;
  logic                 tick;
  logic                 accept;
  logic                 chan_ok;
  logic                 mode_ok;
  logic                 wr_ok;
  mode_t                wr_mode;
  logic [CNT_WIDTH-1:0] period_fix;
  logic [CHANNELS-1:0]  wr_sel;

  // Tick fires in the single cycle where the prescaler wraps
  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler: free-running 0..PRESCALE-1, restarted by sync
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (sync || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Write decode: out-of-range channels and unsupported modes are rejected
  assign accept     = cfg_valid && cfg_ready;
  assign chan_ok    = ({1'b0, cfg_chan} < CHAN_LIM);
  assign wr_mode    = mode_t'(cfg_mode);
  assign period_fix = (cfg_period == '0) ? CNT_WIDTH'(1) : cfg_period;
`ifdef BLINK_PWM_EN
  assign mode_ok = 1'b1;
`else
  assign mode_ok = (wr_mode != MODE_PWM);
  // Duty has no home without PWM support
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif
  assign wr_ok = chan_ok && mode_ok;

  // Handshake: one dead cycle after each accept; error pulse for a rejected accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= ~accept;
      cfg_err   <= accept && !wr_ok;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign wr_sel[i] = accept && wr_ok && (cfg_chan == CHAN_IDX_W'(i));

    blink_chan #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .sync      (sync),
      .wr_en     (wr_sel[i]),
      .wr_mode   (wr_mode),
      .wr_period (period_fix),
`ifdef BLINK_PWM_EN
      .wr_duty   (cfg_duty),
`endif
      .led       (led[i])
    );
  end

endmodule

// File: tb/tb_blink_multi.sv
`timescale 1ns/1ps
module tb_blink_multi;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int P  = 4;
`ifdef BLINK_PWM_EN
  localparam bit PWM_EN = 1'b1;
`else
  localparam bit PWM_EN = 1'b0;
`endif

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          sync       = 1'b0;
  logic          cfg_valid  = 1'b0;
  logic          cfg_ready;
  logic [4:0]    cfg_chan   = 5'd0;
  logic [1:0]    cfg_mode   = 2'd0;
  logic [W-1:0]  cfg_period = '0;
  logic [W-1:0]  cfg_duty   = '0;
  logic          cfg_err;
  logic [CH-1:0] led;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  blink_multi #(
    .CHANNELS  (CH),
    .CNT_WIDTH (W),
    .PRESCALE  (P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sync       (sync),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_chan   (cfg_chan),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_err    (cfg_err),
    .led        (led)
  );

  // Reference model: elapsed cycles/ticks since the last write or restart
  int m_pre;
  bit m_rdy;
  bit m_err;
  int m_mode  [CH];
  int m_per   [CH];
  int m_duty  [CH];
  int m_ticks [CH];
  int m_age   [CH];

  task automatic model_reset();
    m_pre = 0;
    m_rdy = 1'b1;
    m_err = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c]  = 0;
      m_per[c]   = 1;
      m_duty[c]  = 0;
      m_ticks[c] = 0;
      m_age[c]   = 0;
    end
  endtask

  task automatic model_edge();
    bit tk;
    bit acc;
    bit good;
    tk   = (m_pre == P - 1) && !sync;
    acc  = cfg_valid && m_rdy;
    good = (int'(cfg_chan) < CH) && (PWM_EN || (cfg_mode != 2'd3));
    for (int c = 0; c < CH; c++) begin
      if (acc && good && (int'(cfg_chan) == c)) begin
        m_mode[c]  = int'(cfg_mode);
        m_per[c]   = (cfg_period == '0) ? 1 : int'(cfg_period);
        m_duty[c]  = int'(cfg_duty);
        m_ticks[c] = 0;
        m_age[c]   = 0;
      end else begin
        if (m_age[c] < 1000) m_age[c]++;
        if (sync) m_ticks[c] = 0;
        else if (tk) m_ticks[c]++;
      end
    end
    m_pre = sync ? 0 : ((m_pre + 1) % P);
    m_err = acc && !good;
    m_rdy = !acc;
  endtask

  function automatic logic [CH-1:0] exp_led();
    logic [CH-1:0] e;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      if (m_age[c] == 0) begin
        e[c] = 1'b0;
      end else begin
        case (m_mode[c])
          1:       e[c] = 1'b1;
          2:       e[c] = (((m_ticks[c] / m_per[c]) % 2) == 1);
          3:       e[c] = ((m_ticks[c] % m_per[c]) < m_duty[c]);
          default: e[c] = 1'b0;
        endcase
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check("led", 32'(led), 32'(exp_led()));
    check("cfg_ready", 32'(cfg_ready), 32'(m_rdy));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input int ch, input int mode, input int per, input int duty);
    cfg_valid  = 1'b1;
    cfg_chan   = 5'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = W'(per);
    cfg_duty   = W'(duty);
    step();
    cfg_valid  = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_err", 32'(cfg_err), 32'd0);
    run(3);
    rst = 1'b1;

    // Idle after reset
    run(100);

    // ch1 BLINK, half-period 3 ticks
    cfg_write(1, 2, 3, 0);
    run(60);

    // ch2 PWM: duty 1 of 4, then duty above period, then duty 0
    run(1);
    cfg_write(2, 3, 4, 1);
    run(40);
    run(1);
    cfg_write(2, 3, 4, 5);
    run(20);
    run(1);
    cfg_write(2, 3, 4, 0);
    run(20);

    // cfg_valid held for three cycles: first and third are accepted
    run(1);
    cfg_valid  = 1'b1;
    cfg_chan   = 5'd0;
    cfg_mode   = 2'd1;
    cfg_period = W'(1);
    step();
    check("b2b_ready_drop", 32'(cfg_ready), 32'd0);
    cfg_mode   = 2'd2;
    cfg_period = W'(2);
    step();
    check("b2b_ready_back", 32'(cfg_ready), 32'd1);
    cfg_chan   = 5'd3;
    cfg_mode   = 2'd2;
    cfg_period = W'(3);
    step();
    cfg_valid  = 1'b0;
    run(2);

    // Out-of-range channel
    cfg_write(7, 1, 1, 0);
    check("bad_chan_err", 32'(cfg_err), 32'd1);
    run(4);

    // Write ch0 on the edge where a tick fires
    for (int i = 0; (i < P) && (m_pre != P - 1); i++) step();
    cfg_write(0, 2, 2, 0);
    run(30);

    // sync while ch3 is mid-period in BLINK
    run(5);
    sync = 1'b1;
    step();
    sync = 1'b0;
    run(30);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      sync       = ($urandom_range(0, 49) == 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_chan   = 5'($urandom_range(0, 5));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_period = W'($urandom_range(0, 5));
      cfg_duty   = W'($urandom_range(0, 6));
      step();
    end
    sync      = 1'b0;
    cfg_valid = 1'b0;

    // Asynchronous reset between edges with a lit LED (period 0 acts as 1)
    run(1);
    cfg_write(0, 1, 0, 0);
    run(3);
    check("pre_rst_led0", 32'(led[0]), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_ready", 32'(cfg_ready), 32'd1);
    check("async_rst_err", 32'(cfg_err), 32'd0);
    model_reset();
    run(2);
    rst = 1'b1;
    run(20);
    check("post_rst_led", 32'(led), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blink_multi.md
BLINK_MULTI -- requirements
Module: blink_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent LED outputs (1..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of per-channel period and duty fields.
REQ-003 SHALL have parameter PRESCALE, default 4, clk cycles per tick (>=1).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sync, input, 1, synchronous restart of prescaler and all channel counters.
REQ-007 SHALL have port cfg_valid, input, 1, config write request.
REQ-008 SHALL have port cfg_ready, output, 1, config write can be accepted.
REQ-009 SHALL have port cfg_chan, input, 5, target channel index.
REQ-010 SHALL have port cfg_mode, input, 2, mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-011 SHALL have port cfg_period, input, CNT_WIDTH, half-period (BLINK) or full period (PWM) in ticks.
REQ-012 SHALL have port cfg_duty, input, CNT_WIDTH, PWM high ticks per period.
REQ-013 SHALL have port cfg_err, output, 1, one-cycle pulse on rejected write.
REQ-014 SHALL have port led, output, CHANNELS, registered LED drive, 1 = lit.

Function
REQ-015 Prescaler SHALL count 0..PRESCALE-1 and wrap, asserting internal tick for exactly the one cycle in which it wraps.
REQ-016 A write SHALL be accepted when cfg_valid and cfg_ready are both 1 on a rising edge; cfg_ready SHALL drop to 0 for exactly the next cycle, then return to 1.
REQ-017 Accepted write to a valid channel SHALL load mode, period and duty, clear that channel's counter, and force its led to 0 on the following edge.
REQ-018 Accepted write with cfg_chan >= CHANNELS SHALL change no state and pulse cfg_err for one cycle.
REQ-019 A period value of 0 SHALL be treated as 1.
REQ-020 OFF: led = 0; counter held at 0.
REQ-021 ON: led = 1 from the second edge after the write onward.
REQ-022 BLINK: counter increments on each tick; on the tick where counter = period-1, led SHALL toggle and counter SHALL wrap to 0 (first toggle high after period ticks).
REQ-023 PWM: phase counter counts ticks 0..period-1 and wraps; led = (phase < duty); duty >= period SHALL give constant 1; duty = 0 SHALL give constant 0.
REQ-024 Write coinciding with a tick on the same channel: write SHALL win; counter cleared, tick discarded for that channel.
REQ-025 sync = 1 SHALL clear the prescaler, all counters and PWM phases, and set BLINK leds to 0; it SHALL have priority over tick, and a simultaneous write SHALL still be applied.
REQ-026 Counters SHALL be CNT_WIDTH wide and never overflow; wrap is only via REQ-022/023.

Reset
REQ-027 While rst = 0: all modes OFF, periods 1, duties 0, counters 0, prescaler 0, led all 0, cfg_err 0, cfg_ready 1.
REQ-028 Reset assertion mid-operation SHALL take effect immediately, independent of clk.

Configuration
REQ-029 With macro BLINK_PWM_EN defined: PWM mode per REQ-023, per-channel duty register present.
REQ-030 Without BLINK_PWM_EN: no duty storage, cfg_duty ignored; a write with cfg_mode = 3 SHALL be treated as rejected per REQ-018 (no state change, cfg_err pulse).

Structure
REQ-031 Package blink_pkg SHALL hold the 2-bit mode type and constants MODE_OFF/ON/BLINK/PWM and CHAN_IDX_W = 5.
REQ-032 Per-channel counter, mode and led logic SHALL be a sub-module blink_chan, instantiated CHANNELS times; prescaler, handshake and decode stay in blink_multi.

Verification (CHANNELS=4, CNT_WIDTH=8, PRESCALE=4)
REQ-033 Reset release, no writes -> led = 4'b0000, cfg_ready = 1, cfg_err = 0 for 100 cycles.
REQ-034 Write ch1 BLINK period 3 -> led[1] low 12 cycles, then toggles every 12 cycles; other leds stay 0.
REQ-035 Write ch2 PWM period 4 duty 1 -> led[2] high 4 of every 16 cycles; duty 5 -> constant 1; duty 0 -> constant 0; without BLINK_PWM_EN -> cfg_err pulse, led[2] unchanged.
REQ-036 Back-to-back cfg_valid held 3 cycles -> writes accepted on cycles 1 and 3 only; cfg_chan = 7 -> cfg_err pulse, no led change.
REQ-037 Write ch0 on the same edge as a tick, and sync asserted while ch3 is BLINK mid-period -> counter restarts; next toggle exactly period*4 cycles later.
REQ-038 rst pulsed low between clk edges while leds active -> all led 0 immediately, all channels OFF after release.
